// File: rtl/cavlc_pkg.sv
// Shared widths, FSM state type and statistics payload for the CAVLC zigzag scanner.
package cavlc_pkg;

  localparam int unsigned COEFF_W_DEF = 16;
  localparam int unsigned BLK_SIZE    = 16;
  localparam int unsigned IDX_W       = $clog2(BLK_SIZE);
  localparam int unsigned TC_W        = 5;
  localparam int unsigned T1_W        = 2;
  localparam int unsigned TZ_W        = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);
  localparam logic [T1_W-1:0]  T1_MAX   = T1_W'(3);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [TC_W-1:0] total_coeff;
    logic [T1_W-1:0] trailing_ones;
    logic [TZ_W-1:0] total_zeros;
  } cavlc_stats_t;

endpackage

// File: rtl/zigzagOrderROM.sv
// 4x4 zigzag map: zigzag index in, raster position out.
module zigzagOrderROM
  import cavlc_pkg::*;
(
  input  logic [IDX_W-1:0] addr,
  output logic [IDX_W-1:0] data
);

  always_comb begin
    data = '0;
    case (addr)
      4'd0:  data = 4'd0;
      4'd1:  data = 4'd1;
      4'd2:  data = 4'd4;
      4'd3:  data = 4'd8;
      4'd4:  data = 4'd5;
      4'd5:  data = 4'd2;
      4'd6:  data = 4'd3;
      4'd7:  data = 4'd6;
      4'd8:  data = 4'd9;
      4'd9:  data = 4'd12;
      4'd10: data = 4'd13;
      4'd11: data = 4'd10;
      4'd12: data = 4'd7;
      4'd13: data = 4'd11;
      4'd14: data = 4'd14;
      4'd15: data = 4'd15;
    endcase
  end

endmodule

// File: rtl/zigzag_scanner.sv
// Buffers a raster 4x4 block, gathers CAVLC statistics in reverse zigzag order,
// then streams the coefficients out in reverse zigzag order with valid/ready.
module zigzag_scanner
  import cavlc_pkg::*;
#(
  parameter int unsigned COEFF_W = COEFF_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_coeff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_coeff,
  output logic [IDX_W-1:0]   out_zz_idx,
  output logic               out_last,
  output logic [TC_W-1:0]    total_coeff,
  output logic [T1_W-1:0]    trailing_ones,
  output logic [TZ_W-1:0]    total_zeros,
  output logic               stats_valid
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]     scan_k_q, scan_k_d;
  logic [IDX_W-1:0]     emit_k_q, emit_k_d;
  logic                 fetch_done_q, fetch_done_d;
  logic                 seen_nz_q, seen_nz_d;
  logic                 t1_active_q, t1_active_d;
  cavlc_stats_t         stats_q, stats_d;
  logic                 stats_valid_q, stats_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [COEFF_W-1:0]   out_coeff_q, out_coeff_d;
  logic [IDX_W-1:0]     out_zz_idx_q, out_zz_idx_d;
  logic                 out_last_q, out_last_d;

  logic [COEFF_W-1:0]   buffer [BLK_SIZE];
  logic                 buf_we;
  logic [IDX_W-1:0]     rom_addr;
  logic [IDX_W-1:0]     rom_data;
  logic [COEFF_W-1:0]   rd_coeff;
  logic                 rd_nonzero;
  logic                 rd_is_one;
  logic                 emit_load;

  zigzagOrderROM u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  // Single ROM port shared between the statistics scan and the output fetch.
  assign rom_addr   = (state_q == EMIT) ? emit_k_q : scan_k_q;
  assign rd_coeff   = buffer[rom_data];
  assign rd_nonzero = |rd_coeff;
  assign rd_is_one  = (rd_coeff == COEFF_W'(1)) || (rd_coeff == {COEFF_W{1'b1}});

  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    scan_k_d      = scan_k_q;
    emit_k_d      = emit_k_q;
    fetch_done_d  = fetch_done_q;
    seen_nz_d     = seen_nz_q;
    t1_active_d   = t1_active_q;
    stats_d       = stats_q;
    stats_valid_d = stats_valid_q;
    out_valid_d   = out_valid_q;
    out_coeff_d   = out_coeff_q;
    out_zz_idx_d  = out_zz_idx_q;
    out_last_d    = out_last_q;
    buf_we        = 1'b0;
    emit_load     = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          buf_we     = 1'b1;
          load_cnt_d = load_cnt_q + IDX_W'(1);
          if (load_cnt_q == LAST_IDX) begin
            state_d     = SCAN;
            load_cnt_d  = '0;
            scan_k_d    = LAST_IDX;
            stats_d     = '0;
            seen_nz_d   = 1'b0;
            t1_active_d = 1'b1;
          end
        end
      end

      SCAN: begin
        if (rd_nonzero) begin
          stats_d.total_coeff = stats_q.total_coeff + TC_W'(1);
          seen_nz_d           = 1'b1;
          if (t1_active_q && rd_is_one && (stats_q.trailing_ones < T1_MAX)) begin
            stats_d.trailing_ones = stats_q.trailing_ones + T1_W'(1);
          end else begin
            t1_active_d = 1'b0;
          end
        end else if (seen_nz_q) begin
          stats_d.total_zeros = stats_q.total_zeros + TZ_W'(1);
        end
        scan_k_d = scan_k_q - IDX_W'(1);
        if (scan_k_q == '0) begin
          state_d       = EMIT;
          stats_valid_d = 1'b1;
          emit_k_d      = LAST_IDX;
          fetch_done_d  = 1'b0;
        end
      end

      EMIT: begin
        // Output register refills when empty or being drained this cycle.
        emit_load = (!out_valid_q || out_ready) && !fetch_done_q;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if (emit_load) begin
          out_valid_d  = 1'b1;
          out_coeff_d  = rd_coeff;
          out_zz_idx_d = emit_k_q;
          out_last_d   = (emit_k_q == '0);
          if (emit_k_q == '0) begin
            fetch_done_d = 1'b1;
          end else begin
            emit_k_d = emit_k_q - IDX_W'(1);
          end
        end
        if (out_valid_q && out_ready && out_last_q) begin
          state_d       = LOAD;
          stats_valid_d = 1'b0;
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase

    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      load_cnt_q    <= '0;
      scan_k_q      <= '0;
      emit_k_q      <= '0;
      fetch_done_q  <= 1'b0;
      seen_nz_q     <= 1'b0;
      t1_active_q   <= 1'b0;
      stats_q       <= '0;
      stats_valid_q <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_coeff_q   <= '0;
      out_zz_idx_q  <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      scan_k_q      <= scan_k_d;
      emit_k_q      <= emit_k_d;
      fetch_done_q  <= fetch_done_d;
      seen_nz_q     <= seen_nz_d;
      t1_active_q   <= t1_active_d;
      stats_q       <= stats_d;
      stats_valid_q <= stats_valid_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_coeff_q   <= out_coeff_d;
      out_zz_idx_q  <= out_zz_idx_d;
      out_last_q    <= out_last_d;
    end
  end

  // Coefficient storage is fully rewritten before every scan, so it carries no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[load_cnt_q] <= in_coeff;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_coeff     = out_coeff_q;
  assign out_zz_idx    = out_zz_idx_q;
  assign out_last      = out_last_q;
  assign total_coeff   = stats_q.total_coeff;
  assign trailing_ones = stats_q.trailing_ones;
  assign total_zeros   = stats_q.total_zeros;
  assign stats_valid   = stats_valid_q;

endmodule

// File: tb/tb_zigzag_scanner.sv
// Scoreboard bench for zigzag_scanner: directed blocks, stalls, held in_valid and mid-EMIT reset.
module tb_zigzag_scanner;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_coeff = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] out_coeff;
  logic [3:0]    out_zz_idx;
  logic          out_last;
  logic [4:0]    total_coeff;
  logic [1:0]    trailing_ones;
  logic [3:0]    total_zeros;
  logic          stats_valid;

  zigzag_scanner #(.COEFF_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coeff      (in_coeff),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_coeff     (out_coeff),
    .out_zz_idx    (out_zz_idx),
    .out_last      (out_last),
    .total_coeff   (total_coeff),
    .trailing_ones (trailing_ones),
    .total_zeros   (total_zeros),
    .stats_valid   (stats_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] coeff;
    logic [3:0]    idx;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [4:0] tc;
    logic [1:0] t1;
    logic [3:0] tz;
  } stat_t;

  beat_t beat_q[$];
  stat_t stat_q[$];
  time   acc_q[$];

  int checks = 0;
  int errors = 0;
  int busy_starts = 0;
  int busy_ends = 0;
  int busy_aborts = 0;
  bit stall_en = 1'b0;

  int zz[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  logic [CW-1:0] blk [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream backpressure
  always @(posedge clk) begin
    #1;
    out_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake
  beat_t         m_beat;
  stat_t         m_stat;
  time           m_t;
  bit            prev_stall = 1'b0;
  bit            prev_valid = 1'b0;
  logic [CW-1:0] prev_coeff;
  logic [3:0]    prev_idx;
  logic          prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_coeff", 32'(out_coeff), 32'(prev_coeff));
        check("stall_idx", 32'(out_zz_idx), 32'(prev_idx));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          check("latency_unexpected_rise", 32'd1, 32'd0);
        end else begin
          m_t = acc_q.pop_front();
          check("latency_edges", 32'(($time - 5 - m_t) / 10), 32'd17);
        end
      end
      if (busy_starts != busy_ends + busy_aborts) begin
        check("in_ready_busy", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 32'd1, 32'd0);
        end else begin
          m_beat = beat_q.pop_front();
          check("beat_coeff", 32'(out_coeff), 32'(m_beat.coeff));
          check("beat_idx", 32'(out_zz_idx), 32'(m_beat.idx));
          check("beat_last", 32'(out_last), 32'(m_beat.last));
        end
        if (stat_q.size() == 0) begin
          check("stats_unexpected", 32'd1, 32'd0);
        end else begin
          m_stat = stat_q[0];
          check("stats_valid", 32'(stats_valid), 32'd1);
          check("total_coeff", 32'(total_coeff), 32'(m_stat.tc));
          check("trailing_ones", 32'(trailing_ones), 32'(m_stat.t1));
          check("total_zeros", 32'(total_zeros), 32'(m_stat.tz));
          if (out_last) begin
            void'(stat_q.pop_front());
            busy_ends++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_coeff = out_coeff;
      prev_idx   = out_zz_idx;
      prev_last  = out_last;
    end
  end

  task automatic clear_blk();
    for (int i = 0; i < 16; i++) blk[i] = '0;
  endtask

  // Queue the expected beats/stats, then feed blk in raster order.
  task automatic send_block(input logic [4:0] tc, input logic [1:0] t1,
                            input logic [3:0] tz, input bit hold);
    beat_t e;
    stat_t s;
    for (int k = 15; k >= 0; k--) begin
      e.coeff = blk[zz[k]];
      e.idx   = 4'(k);
      e.last  = (k == 0);
      beat_q.push_back(e);
    end
    s.tc = tc;
    s.t1 = t1;
    s.tz = tz;
    stat_q.push_back(s);
    for (int p = 0; p < 16; p++) begin
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      in_valid = 1'b1;
      in_coeff = blk[p];
      while (!acc && n < 600) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (p == 15) begin
        acc_q.push_back($time - 1);
        busy_starts++;
      end
    end
    if (hold) in_coeff = 16'h7bad;
    else      in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((busy_starts != busy_ends + busy_aborts || beat_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stats_valid", 32'(stats_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_total_coeff", 32'(total_coeff), 32'd0);
    check("rst_trailing_ones", 32'(trailing_ones), 32'd0);
    check("rst_total_zeros", 32'(total_zeros), 32'd0);
    check("rst_out_zz_idx", 32'(out_zz_idx), 32'd0);
    check("rst_out_coeff", 32'(out_coeff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Ramp: value = position + 1
    for (int i = 0; i < 16; i++) blk[i] = CW'(i + 1);
    send_block(5'd16, 2'd0, 4'd0, 1'b0);
    wait_drain();

    // All-zero block still produces 16 beats
    clear_blk();
    send_block(5'd0, 2'd0, 4'd0, 1'b0);
    wait_drain();

    // Three trailing ones capped, fourth +-1 ends the run
    clear_blk();
    blk[0] = CW'(5);
    blk[1] = 16'hffff;
    blk[4] = CW'(1);
    blk[5] = CW'(1);
    blk[8] = 16'hffff;
    send_block(5'd5, 2'd3, 4'd0, 1'b0);
    wait_drain();

    // Gap of zero coefficients below the last nonzero
    clear_blk();
    blk[0] = CW'(3);
    blk[2] = 16'hffff;
    send_block(5'd2, 2'd1, 4'd4, 1'b0);
    wait_drain();

    // All -1 under random stalls with in_valid held through SCAN/EMIT
    stall_en = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 16'hffff;
    send_block(5'd16, 2'd3, 4'd0, 1'b1);
    wait_drain();
    in_valid = 1'b0;
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset while beat 7 (zigzag index 8) is presented
    for (int i = 0; i < 16; i++) blk[i] = CW'(i + 1);
    send_block(5'd16, 2'd0, 4'd0, 1'b0);
    begin
      int n;
      bit hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 400) begin
        @(negedge clk);
        #2;
        hit = out_valid && (out_zz_idx == 4'd8);
        n++;
      end
      check("reset_target_beat", 32'(hit), 32'd1);
    end
    rst_n = 1'b0;
    beat_q.delete();
    stat_q.delete();
    acc_q.delete();
    busy_aborts++;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_stats_valid", 32'(stats_valid), 32'd0);
    check("abort_out_coeff", 32'(out_coeff), 32'd0);
    check("abort_out_zz_idx", 32'(out_zz_idx), 32'd0);
    check("abort_total_coeff", 32'(total_coeff), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single trailing one at the highest frequency, stalled output
    stall_en = 1'b1;
    clear_blk();
    blk[15] = CW'(1);
    send_block(5'd1, 2'd1, 4'd15, 1'b0);
    wait_drain();
    stall_en = 1'b0;

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(beat_q.size() + stat_q.size() + acc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
